// File: rtl/wb_burst_ram_slave.sv
// -----------------------------------------------------------------------------
// wb_burst_ram_slave
//
// Wishbone slave RAM sitting directly behind the a25 core's Wishbone master.
// It accepts the master's single and 4-beat burst cycles one beat at a time.
// For every beat it waits WAIT_STATES idle cycles and then returns a
// registered one-cycle acknowledge. It serves as the bench memory model and
// as on-chip boot/scratch RAM.
//
// Beat handshake:
//   A beat is requested while i_wb_cyc & i_wb_stb are both high in IDLE.
//   The slave captures adr/sel/we/dat on that edge.
//   Exactly one cycle of o_wb_ack (or o_wb_err) marks completion.
//   The master holds the request until it sees the ack. Anything presented
//   during the ack cycle still belongs to the finished beat and is ignored.
//   Dropping i_wb_cyc while the beat is waiting abandons it silently.
//
// Optional feature (macro WB_RAM_RANGE_ERR_EN):
//   defined   - a beat with non-zero address bits above the word index
//               completes with o_wb_err instead of o_wb_ack. It writes
//               nothing and returns zero data.
//   undefined - upper address bits are ignored, so the address aliases
//               modulo the depth. o_wb_err is tied low.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset (released synchronously upstream)
//   i_wb_adr  byte address. The word index is taken from the bits just above
//             the byte-lane bits.
//   i_wb_sel  byte enables
//   i_wb_we   1 = write
//   i_wb_dat  write data
//   i_wb_cyc  bus cycle active
//   i_wb_stb  beat strobe
//   o_wb_dat  read data, non-zero only during the ack cycle of a read
//   o_wb_ack  beat acknowledge, single-cycle pulse
//   o_wb_err  error acknowledge, single-cycle pulse
//   o_busy    high while a beat is in WAIT or ACK
// -----------------------------------------------------------------------------
module wb_burst_ram_slave #(
  parameter int WB_DWIDTH   = 128,
  parameter int WB_SWIDTH   = WB_DWIDTH / 8,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  output logic                 o_busy
);

  localparam int BYTE_W = $clog2(WB_SWIDTH);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int IDX_LO = BYTE_W;
  localparam int IDX_HI = ADDR_W + BYTE_W - 1;

  // The counter holds the number of WAIT cycles still to go after the
  // current one. With zero wait states the counter is never loaded.
  localparam int         WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_LOAD_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]           wait_cnt;
  logic [3:0]           wait_cnt_next;

  // Captured beat
  logic [ADDR_W-1:0]    idx_q;
  logic [WB_SWIDTH-1:0] sel_q;
  logic                 we_q;
  logic [WB_DWIDTH-1:0] wdat_q;
  logic                 rng_q;

  // Registered outputs
  logic                 ack_q;
  logic [WB_DWIDTH-1:0] rdat_q;

  logic [WB_DWIDTH-1:0] mem [DEPTH];

  logic                 req;
  logic [ADDR_W-1:0]    req_idx;
  logic                 req_rng;

  // The beat that is heading into ACK. From IDLE (zero wait states) it is
  // still on the bus; from WAIT it has already been captured.
  logic [ADDR_W-1:0]    beat_idx;
  logic                 beat_we;
  logic                 beat_rng;

  assign req     = i_wb_cyc & i_wb_stb;
  assign req_idx = i_wb_adr[IDX_HI:IDX_LO];

  // Byte-lane bits never take part in decoding. Upper bits take part only
  // when range checking is enabled.
  wire unused_adr = ^i_wb_adr;

`ifdef WB_RAM_RANGE_ERR_EN
  assign req_rng = |i_wb_adr[31:IDX_HI+1];
`else
  assign req_rng = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_ACK;
          end else begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // An abort outranks the ack.
        // A beat dropped in its last WAIT cycle is still abandoned.
        if (!i_wb_cyc) begin
          state_next    = ST_IDLE;
          wait_cnt_next = 4'd0;
        end else if (wait_cnt == 4'd0) begin
          state_next = ST_ACK;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next    = ST_IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      wdat_q <= '0;
      rng_q  <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      idx_q  <= req_idx;
      sel_q  <= i_wb_sel;
      we_q   <= i_wb_we;
      wdat_q <= i_wb_dat;
      rng_q  <= req_rng;
    end
  end

  always_comb begin
    beat_idx = idx_q;
    beat_we  = we_q;
    beat_rng = rng_q;
    if (state == ST_IDLE) begin
      beat_idx = req_idx;
      beat_we  = i_wb_we;
      beat_rng = req_rng;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered response
  // The response flops are loaded on the edge that enters ACK. They are
  // therefore valid for exactly the ACK cycle and return to zero on the
  // edge that leaves it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= (state_next == ST_ACK) && !beat_rng;
      if (state_next == ST_ACK && !beat_we && !beat_rng) begin
        rdat_q <= mem[beat_idx];
      end else begin
        rdat_q <= '0;
      end
    end
  end

`ifdef WB_RAM_RANGE_ERR_EN
  logic err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_next == ST_ACK) && beat_rng;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // RAM write
  // The write commits on the edge that ends ACK. The master has already
  // sampled the ack by then, so an abort in ACK still writes. A reset during
  // ACK leaves the state machine in IDLE before that edge, so the write
  // never happens.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (state == ST_ACK && we_q && !rng_q) begin
      for (int b = 0; b < WB_SWIDTH; b++) begin
        if (sel_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy   = (state != ST_IDLE);
    o_wb_ack = ack_q;
    o_wb_dat = rdat_q;
`ifdef WB_RAM_RANGE_ERR_EN
    o_wb_err = err_q;
`else
    o_wb_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_ram_slave
//
// Directed bench for wb_burst_ram_slave.
//   dut2: WAIT_STATES=2. Used for single beats, byte lanes, abort, reset and
//         the range check.
//   dut0: WAIT_STATES=0. Used for 4-beat bursts driven by a small model of
//         the a25 master (IDLE -> BURST1 -> BURST2 -> BURST3 -> WAIT_ACK).
// -----------------------------------------------------------------------------
module tb_wb_burst_ram_slave;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // dut2 bus (WAIT_STATES = 2)
  // ---------------------------------------------------------------------------
  logic [31:0]  adr;
  logic [15:0]  sel;
  logic         we;
  logic [127:0] wdat;
  logic         cyc;
  logic         stb;
  logic [127:0] rdat;
  logic         ack;
  logic         err;
  logic         busy;

  wb_burst_ram_slave #(.WAIT_STATES(2)) dut2 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_adr (adr),
    .i_wb_sel (sel),
    .i_wb_we  (we),
    .i_wb_dat (wdat),
    .i_wb_cyc (cyc),
    .i_wb_stb (stb),
    .o_wb_dat (rdat),
    .o_wb_ack (ack),
    .o_wb_err (err),
    .o_busy   (busy)
  );

  // ---------------------------------------------------------------------------
  // dut0 bus (WAIT_STATES = 0)
  // ---------------------------------------------------------------------------
  logic [31:0]  b_adr;
  logic [15:0]  b_sel;
  logic         b_we;
  logic [127:0] b_wdat;
  logic         b_cyc;
  logic         b_stb;
  logic [127:0] b_rdat;
  logic         b_ack;
  logic         b_err;
  logic         b_busy;

  wb_burst_ram_slave #(.WAIT_STATES(0)) dut0 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_adr (b_adr),
    .i_wb_sel (b_sel),
    .i_wb_we  (b_we),
    .i_wb_dat (b_wdat),
    .i_wb_cyc (b_cyc),
    .i_wb_stb (b_stb),
    .o_wb_dat (b_rdat),
    .o_wb_ack (b_ack),
    .o_wb_err (b_err),
    .o_busy   (b_busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and comparison
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one beat on dut2, held until ack/err or a 20-cycle budget runs out.
  // lat counts cycles from the request cycle to the response cycle.
  // ---------------------------------------------------------------------------
  task automatic beat(input logic w, input logic [31:0] a, input logic [15:0] s,
                      input logic [127:0] d, output logic [127:0] rd,
                      output int lat, output logic got_ack, output logic got_err);
    @(posedge clk); #1;
    adr = a; sel = s; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
    rd = '0; lat = 0; got_ack = 1'b0; got_err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        lat = i; got_ack = ack; got_err = err; rd = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: a25-style 4-beat burst on dut0.
  // The next address is presented in the ack cycle.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    M_IDLE, M_BURST1, M_BURST2, M_BURST3, M_WAIT_ACK
  } mstate_t;

  mstate_t      mstate;
  logic [3:0]   visited;
  int           nacks;
  int           ack_at [4];
  logic [127:0] bw [4];
  logic [127:0] br [4];

  task automatic burst(input logic w, input logic [31:0] base);
    @(posedge clk); #1;
    b_adr = base; b_we = w; b_sel = '1; b_wdat = bw[0]; b_cyc = 1'b1; b_stb = 1'b1;
    mstate = M_BURST1; visited = 4'b0001; nacks = 0;
    for (int i = 0; i < 4; i++) begin
      ack_at[i] = -1;
      br[i] = '0;
    end
    for (int c = 1; c <= 16 && nacks < 4; c++) begin
      @(posedge clk); #1;
      if (b_ack) begin
        ack_at[nacks] = c;
        br[nacks] = b_rdat;
        nacks++;
        if (nacks == 4) begin
          b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
          mstate = M_IDLE;
        end else begin
          b_adr  = base + 32'(nacks * 16);
          b_wdat = bw[nacks];
          visited[nacks] = 1'b1;
          case (nacks)
            1:       mstate = M_BURST2;
            2:       mstate = M_BURST3;
            default: mstate = M_WAIT_ACK;
          endcase
        end
      end
    end
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    // Any ack after the fourth one is a stray and inflates the count.
    repeat (4) begin
      @(posedge clk); #1;
      if (b_ack) nacks++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] D0   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] OLD3 = 128'h3333_0000_3333_0000_3333_0000_3333_0000;
  localparam logic [127:0] NEW3 = 128'hFFFF_3333_FFFF_3333_FFFF_3333_FFFF_3333;
  localparam logic [127:0] OLD4 = 128'h4444_1234_4444_1234_4444_1234_4444_1234;
  localparam logic [127:0] NEW4 = 128'hBBBB_BBBB_CCCC_CCCC_DDDD_DDDD_EEEE_EEEE;

  logic [127:0] rd;
  int           lat;
  logic         a;
  logic         e;
  logic         seen;

  initial begin
    adr = '0; sel = '0; we = 1'b0; wdat = '0; cyc = 1'b0; stb = 1'b0;
    b_adr = '0; b_sel = '0; b_we = 1'b0; b_wdat = '0; b_cyc = 1'b0; b_stb = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack",  {127'd0, ack},  128'd0);
    chk("reset_err",  {127'd0, err},  128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_dat",  rdat,           128'd0);
    chk("reset_busy0",{127'd0, b_busy}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write / read: ack lands 3 cycles after the request cycle.
    beat(1'b1, 32'h100, 16'hFFFF, D1, rd, lat, a, e);
    chk("wr_ack", {127'd0, a}, 128'd1);
    chk("wr_lat", 128'(lat),   128'd3);
    beat(1'b0, 32'h100, 16'hFFFF, '0, rd, lat, a, e);
    chk("rd_ack",  {127'd0, a}, 128'd1);
    chk("rd_err",  {127'd0, e}, 128'd0);
    chk("rd_lat",  128'(lat),   128'd3);
    chk("rd_data", rd,          D1);
    @(posedge clk); #1;
    chk("ack_single_cycle", {127'd0, ack}, 128'd0);
    chk("dat_zero_after",   rdat,          128'd0);

    // Byte lanes
    beat(1'b1, 32'h140, 16'hFFFF, {16{8'h55}}, rd, lat, a, e);
    beat(1'b1, 32'h140, 16'h000F, {16{8'hAA}}, rd, lat, a, e);
    beat(1'b0, 32'h140, 16'hFFFF, '0, rd, lat, a, e);
    chk("lane_data", rd, 128'h5555_5555_5555_5555_5555_5555_AAAA_AAAA);
    // A write with no byte enables is acked but changes nothing.
    beat(1'b1, 32'h140, 16'h0000, '1, rd, lat, a, e);
    chk("sel0_ack", {127'd0, a}, 128'd1);
    beat(1'b0, 32'h140, 16'hFFFF, '0, rd, lat, a, e);
    chk("sel0_data", rd, 128'h5555_5555_5555_5555_5555_5555_AAAA_AAAA);

    // Abort: cyc drops one cycle into WAIT.
    // stb stays high afterwards and must not start a beat on its own.
    beat(1'b1, 32'h300, 16'hFFFF, OLD3, rd, lat, a, e);
    @(posedge clk); #1;
    adr = 32'h300; sel = 16'hFFFF; we = 1'b1; wdat = NEW3; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy_wait", {127'd0, busy}, 128'd1);
    cyc = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ack | err;
    end
    chk("abort_no_resp", {127'd0, seen}, 128'd0);
    chk("abort_idle",    {127'd0, busy}, 128'd0);
    stb = 1'b0; we = 1'b0;
    beat(1'b0, 32'h300, 16'hFFFF, '0, rd, lat, a, e);
    chk("abort_data", rd, OLD3);

    // Asynchronous reset in the middle of WAIT
    beat(1'b1, 32'h180, 16'hFFFF, OLD4, rd, lat, a, e);
    @(posedge clk); #1;
    adr = 32'h180; sel = 16'hFFFF; we = 1'b1; wdat = NEW4; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy_before", {127'd0, busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ack",  {127'd0, ack},  128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 32'h180, 16'hFFFF, '0, rd, lat, a, e);
    chk("rst_data", rd, OLD4);

    // Upper address bits
    beat(1'b1, 32'h0, 16'hFFFF, D0, rd, lat, a, e);
    beat(1'b0, 32'h8000_0000, 16'hFFFF, '0, rd, lat, a, e);
`ifdef WB_RAM_RANGE_ERR_EN
    chk("range_err",  {127'd0, e}, 128'd1);
    chk("range_ack",  {127'd0, a}, 128'd0);
    chk("range_dat",  rd,          128'd0);
    chk("range_lat",  128'(lat),   128'd3);
    beat(1'b1, 32'h8000_0000, 16'hFFFF, D1, rd, lat, a, e);
    beat(1'b0, 32'h0, 16'hFFFF, '0, rd, lat, a, e);
    chk("range_nowrite", rd, D0);
`else
    chk("alias_ack",  {127'd0, a}, 128'd1);
    chk("alias_err",  {127'd0, e}, 128'd0);
    chk("alias_data", rd,          D0);
`endif

    // 4-beat bursts with zero wait states: write 0x200..0x230, then read back.
    bw[0] = 128'h0000_0000_0000_0000_0000_0000_0000_0200;
    bw[1] = 128'h1111_1111_1111_1111_1111_1111_1111_0210;
    bw[2] = 128'h2222_2222_2222_2222_2222_2222_2222_0220;
    bw[3] = 128'h3333_3333_3333_3333_3333_3333_3333_0230;
    burst(1'b1, 32'h200);
    chk("bwr_nacks", 128'(nacks), 128'd4);
    burst(1'b0, 32'h200);
    chk("brd_nacks", 128'(nacks), 128'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("brd_ack_cycle%0d", i), 128'(ack_at[i]), 128'(2 * i + 1));
      chk($sformatf("brd_data%0d", i),      br[i],           bw[i]);
    end
    chk("brd_master_idle",    128'(mstate),  128'(M_IDLE));
    chk("brd_master_visited", 128'(visited), 128'hF);
    chk("brd_no_err",         {127'd0, b_err}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
